// File: rtl/multichannel_amplitude_detector.sv
// Multichannel amplitude detector: peak-absolute or half peak-to-peak over a window of
// sample strobes, gated by the IAGC status word, with a one-cycle valid per result.
module multichannel_amplitude_detector #(
  parameter int unsigned NB_CHANNELS          = 2,
  parameter int unsigned IAGC_STATUS_SIZE     = 4,
  parameter int unsigned SAMPLER_DATA_SIZE    = 16,
  parameter int unsigned AMPLITUDE_COUNT_SIZE = 16,
  parameter logic [IAGC_STATUS_SIZE-1:0] MEASURE_STATUS = 4'b0001
) (
  input  logic                                       i_clock,
  input  logic                                       i_reset,
  input  logic                                       i_sample,
  input  logic [IAGC_STATUS_SIZE-1:0]                i_iagc_status,
  input  logic                                       i_mode,
  input  logic [NB_CHANNELS*SAMPLER_DATA_SIZE-1:0]   i_data,
  input  logic [AMPLITUDE_COUNT_SIZE-1:0]            i_amplitude_count,
  output logic [NB_CHANNELS*SAMPLER_DATA_SIZE-1:0]   o_amplitude,
  output logic                                       o_valid,
  output logic                                       o_busy
);

  localparam int unsigned W  = SAMPLER_DATA_SIZE;
  localparam int unsigned CW = AMPLITUDE_COUNT_SIZE;

  typedef enum logic [1:0] {StIdle, StAcquire, StDone} state_e;

  state_e              state_q;
  logic                sample_q;
  logic                mode_q;
  logic                valid_q;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_inc;
  logic [NB_CHANNELS*W-1:0] amp_q;
  logic [NB_CHANNELS*W-1:0] result;
  logic                strobe;
  logic                measure;
  logic                start_ok;
  logic                update;
  logic                first;

  assign strobe   = i_sample & ~sample_q;
  assign measure  = (i_iagc_status == MEASURE_STATUS);
  assign start_ok = measure && (i_amplitude_count != '0);
  assign cnt_inc  = cnt_q + 1'b1;
  // Abort has priority, so a strobe only counts while status still enables measurement.
  assign update   = (state_q == StAcquire) && measure && strobe;
  assign first    = (cnt_q == '0);

  for (genvar n = 0; n < NB_CHANNELS; n++) begin : g_ch
    logic signed [W-1:0] sample;
    logic signed [W-1:0] max_q;
    logic signed [W-1:0] min_q;
    logic signed [W:0]   mx_ext;
    logic signed [W:0]   mn_ext;
    logic signed [W:0]   abs_mx;
    logic signed [W:0]   abs_mn;
    logic signed [W:0]   diff;
    logic [W:0]          peak;

    assign sample = i_data[n*W +: W];

    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
        max_q <= '0;
        min_q <= '0;
      end else if (update) begin
        if (first || (sample > max_q)) max_q <= sample;
        if (first || (sample < min_q)) min_q <= sample;
      end
    end

    // One extra bit so |-2^(W-1)| and max-min are representable before narrowing.
    assign mx_ext = {max_q[W-1], max_q};
    assign mn_ext = {min_q[W-1], min_q};
    assign abs_mx = mx_ext[W] ? -mx_ext : mx_ext;
    assign abs_mn = mn_ext[W] ? -mn_ext : mn_ext;
    assign peak   = (abs_mx > abs_mn) ? abs_mx : abs_mn;
    assign diff   = mx_ext - mn_ext;

    assign result[n*W +: W] = mode_q ? diff[W:1] : peak[W-1:0];
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= StIdle;
      sample_q <= 1'b0;
      mode_q   <= 1'b0;
      valid_q  <= 1'b0;
      count_q  <= '0;
      cnt_q    <= '0;
      amp_q    <= '0;
    end else begin
      sample_q <= i_sample;
      valid_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_q <= StAcquire;
            count_q <= i_amplitude_count;
            mode_q  <= i_mode;
            cnt_q   <= '0;
          end
        end
        StAcquire: begin
          if (!measure) begin
            state_q <= StIdle;
          end else if (strobe) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == count_q) state_q <= StDone;
          end
        end
        StDone: begin
          amp_q   <= result;
          valid_q <= 1'b1;
          cnt_q   <= '0;
          if (start_ok) begin
            state_q <= StAcquire;
            count_q <= i_amplitude_count;
            mode_q  <= i_mode;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_amplitude = amp_q;
  assign o_valid     = valid_q;
  assign o_busy      = (state_q != StIdle);

endmodule
